// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer
// Drives an external 4-bit combinational ALU one nibble at a time to perform
// a W = 4*NIBBLES bit ADD or SUB. The ALU has no carry-in, so each nibble
// normally takes two passes: P1 computes a_nib op b_nib, and P2 folds the
// incoming carry/borrow into that partial result.
//
// Optional build macro: ALU_NIBBLE_SEQUENCER_SKIP_EN
//   When defined, a nibble entered with no pending carry/borrow is finished
//   in P1 and its P2 pass is skipped. Results and flags are the same in both
//   builds; only the latency changes.
//
// Ports:
//   clk_i, rst_i         clock (rising edge), synchronous active-high reset
//   req_valid_i/ready_o  request handshake; req_sub_i, req_a_i, req_b_i
//   rsp_valid_o/ready_i  response handshake; rsp_result_o and carry/zero/
//                        overflow flags (carry means borrow for SUB)
//   alu_a_o, alu_b_o,    ALU operands and opcode (3'b000 ADD, 3'b001 SUB)
//   alu_op_o
//   alu_result_i,        ALU result and flags, combinational from alu_*_o
//   alu_carry_i,
//   alu_zero_i,
//   alu_overflow_i       not used
module alu_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_sub_i,
  input  logic [4*NIBBLES-1:0] req_a_i,
  input  logic [4*NIBBLES-1:0] req_b_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [4*NIBBLES-1:0] rsp_result_o,
  output logic                 rsp_carry_o,
  output logic                 rsp_zero_o,
  output logic                 rsp_overflow_o,
  output logic [3:0]           alu_a_o,
  output logic [3:0]           alu_b_o,
  output logic [2:0]           alu_op_o,
  input  logic [3:0]           alu_result_i,
  input  logic                 alu_carry_i,
  input  logic                 alu_zero_i,
  input  logic                 alu_overflow_i
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST_NIB = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    P1,
    P2,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    opA_q, opA_d;
  logic [W-1:0]    opB_q, opB_d;
  logic            sub_q, sub_d;
  logic [IW-1:0]   nibIdx_q, nibIdx_d;
  logic            cin_q, cin_d;
  logic            zeroAcc_q, zeroAcc_d;
  logic [3:0]      tmp_q, tmp_d;
  logic            c1_q, c1_d;
  logic [W-1:0]    result_q, result_d;

  logic [IW+1:0]   nibShift;
  logic [W-1:0]    opAShifted;
  logic [W-1:0]    opBShifted;
  logic [W-1:0]    resultWithNib;
  logic            lastNib;
  logic            isDone;
  logic            unusedAluOverflow;

  assign unusedAluOverflow = alu_overflow_i;

  // Current nibble of each operand, and the result with nibble i replaced by
  // the ALU output. Both result-writing passes take the value straight from
  // the ALU, so one insertion path serves them both.
  assign nibShift      = {nibIdx_q, 2'b00};
  assign opAShifted    = opA_q >> nibShift;
  assign opBShifted    = opB_q >> nibShift;
  assign resultWithNib = (result_q & ~(W'(4'hF) << nibShift))
                       | (W'(alu_result_i) << nibShift);
  assign lastNib       = (nibIdx_q == LAST_NIB);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      opA_q     <= '0;
      opB_q     <= '0;
      sub_q     <= 1'b0;
      nibIdx_q  <= '0;
      cin_q     <= 1'b0;
      zeroAcc_q <= 1'b0;
      tmp_q     <= '0;
      c1_q      <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      sub_q     <= sub_d;
      nibIdx_q  <= nibIdx_d;
      cin_q     <= cin_d;
      zeroAcc_q <= zeroAcc_d;
      tmp_q     <= tmp_d;
      c1_q      <= c1_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opA_d     = opA_q;
    opB_d     = opB_q;
    sub_d     = sub_q;
    nibIdx_d  = nibIdx_q;
    cin_d     = cin_q;
    zeroAcc_d = zeroAcc_q;
    tmp_d     = tmp_q;
    c1_d      = c1_q;
    result_d  = result_q;
    alu_a_o   = 4'h0;
    alu_b_o   = 4'h0;
    alu_op_o  = 3'b000;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          opA_d     = req_a_i;
          opB_d     = req_b_i;
          sub_d     = req_sub_i;
          nibIdx_d  = '0;
          cin_d     = 1'b0;
          zeroAcc_d = 1'b1;
          state_d   = P1;
        end
      end

      P1: begin
        alu_a_o  = opAShifted[3:0];
        alu_b_o  = opBShifted[3:0];
        alu_op_o = {2'b00, sub_q};
        tmp_d    = alu_result_i;
        c1_d     = alu_carry_i;
        state_d  = P2;
`ifdef ALU_NIBBLE_SEQUENCER_SKIP_EN
        // Nothing to fold in, so the P1 result is already the final nibble.
        if (!cin_q) begin
          result_d  = resultWithNib;
          cin_d     = alu_carry_i;
          zeroAcc_d = zeroAcc_q & alu_zero_i;
          if (lastNib) begin
            state_d = DONE;
          end else begin
            nibIdx_d = nibIdx_q + 1'b1;
            state_d  = P1;
          end
        end
`endif
      end

      P2: begin
        // At most one of the two passes can carry/borrow; OR them to form
        // the carry into the next nibble.
        alu_a_o   = tmp_q;
        alu_b_o   = {3'b000, cin_q};
        alu_op_o  = {2'b00, sub_q};
        result_d  = resultWithNib;
        cin_d     = c1_q | alu_carry_i;
        zeroAcc_d = zeroAcc_q & alu_zero_i;
        if (lastNib) begin
          state_d = DONE;
        end else begin
          nibIdx_d = nibIdx_q + 1'b1;
          state_d  = P1;
        end
      end

      DONE: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Flags are only meaningful in DONE; gating them keeps the response port
  // quiet between operations.
  assign isDone         = (state_q == DONE);
  assign req_ready_o    = (state_q == IDLE);
  assign rsp_valid_o    = isDone;
  assign rsp_result_o   = result_q;
  assign rsp_carry_o    = isDone & cin_q;
  assign rsp_zero_o     = isDone & zeroAcc_q;
  assign rsp_overflow_o = isDone & (sub_q
    ? ((~opA_q[W-1] &  opB_q[W-1] &  result_q[W-1]) |
       ( opA_q[W-1] & ~opB_q[W-1] & ~result_q[W-1]))
    : ((~opA_q[W-1] & ~opB_q[W-1] &  result_q[W-1]) |
       ( opA_q[W-1] &  opB_q[W-1] & ~result_q[W-1])));

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb_alu_nibble_sequencer
// Bench for alu_nibble_sequencer with NIBBLES=4 (16-bit operands). Contains a
// behavioural 4-bit ALU wired to the alu_* ports and a whole-word arithmetic
// reference for results, flags and latency. Honours the
// ALU_NIBBLE_SEQUENCER_SKIP_EN macro when computing expected latency.
module tb_alu_nibble_sequencer;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst;
  logic         reqValid;
  logic         reqReady;
  logic         reqSub;
  logic [W-1:0] reqA;
  logic [W-1:0] reqB;
  logic         rspValid;
  logic         rspReady;
  logic [W-1:0] rspResult;
  logic         rspCarry;
  logic         rspZero;
  logic         rspOverflow;
  logic [3:0]   aluA;
  logic [3:0]   aluB;
  logic [2:0]   aluOp;
  logic [3:0]   aluResult;
  logic         aluCarry;
  logic         aluZero;
  logic         aluOverflow;
  logic [4:0]   aluFull;

  int testCount = 0;
  int failCount = 0;
  int aluOpViolations = 0;

  alu_nibble_sequencer #(.NIBBLES(NIB)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (reqValid),
    .req_ready_o    (reqReady),
    .req_sub_i      (reqSub),
    .req_a_i        (reqA),
    .req_b_i        (reqB),
    .rsp_valid_o    (rspValid),
    .rsp_ready_i    (rspReady),
    .rsp_result_o   (rspResult),
    .rsp_carry_o    (rspCarry),
    .rsp_zero_o     (rspZero),
    .rsp_overflow_o (rspOverflow),
    .alu_a_o        (aluA),
    .alu_b_o        (aluB),
    .alu_op_o       (aluOp),
    .alu_result_i   (aluResult),
    .alu_carry_i    (aluCarry),
    .alu_zero_i     (aluZero),
    .alu_overflow_i (aluOverflow)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the team's 4-bit ALU (carry means borrow on SUB).
  always_comb begin
    if (aluOp == 3'b001) aluFull = {1'b0, aluA} - {1'b0, aluB};
    else                 aluFull = {1'b0, aluA} + {1'b0, aluB};
    aluResult   = aluFull[3:0];
    aluCarry    = aluFull[4];
    aluZero     = (aluFull[3:0] == 4'h0);
    aluOverflow = (aluA[3] == (aluB[3] ^ (aluOp == 3'b001))) && (aluFull[3] != aluA[3]);
  end

  // The sequencer must only ever issue ADD or SUB.
  always @(negedge clk) begin
    if (!rst && aluOp !== 3'b000 && aluOp !== 3'b001) aluOpViolations++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Whole-word reference using plain integer arithmetic.
  task automatic refModel(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r, output logic c, output logic z, output logic o);
    int sa, sb, sr;
    int ua, ub;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    if (sub) begin
      r  = W'(ua - ub);
      c  = (ua < ub);
      sr = sa - sb;
    end else begin
      r  = W'(ua + ub);
      c  = (ua + ub) >= 65536;
      sr = sa + sb;
    end
    z = (r == '0);
    o = (sr > 32767) || (sr < -32768);
  endtask

  function automatic int expLatency(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef ALU_NIBBLE_SEQUENCER_SKIP_EN
    int n;
    int m;
    int am;
    int bm;
    n = NIB;
    for (int i = 1; i < NIB; i++) begin
      m  = 1 << (4 * i);
      am = int'(a) % m;
      bm = int'(b) % m;
      if (sub ? (am < bm) : (am + bm >= m)) n++;
    end
    return n;
`else
    if (sub || a != b || !sub) return 2 * NIB;
    return 2 * NIB;
`endif
  endfunction

  // Issues one request, counts edges from acceptance to rsp_valid, captures
  // the response and completes the handshake.
  task automatic runOp(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic c, output logic z, output logic o,
                       output int lat, output bit timedOut);
    int guard;
    timedOut = 1'b0;
    rspReady = 1'b1;
    reqSub   = sub;
    reqA     = a;
    reqB     = b;
    reqValid = 1'b1;
    guard    = 0;
    while (!reqReady && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!reqReady) timedOut = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
    reqA     = W'($urandom);
    reqB     = W'($urandom);
    reqSub   = 1'($urandom);
    lat = 0;
    while (!rspValid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rspValid) timedOut = 1'b1;
    r = rspResult;
    c = rspCarry;
    z = rspZero;
    o = rspOverflow;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; reqValid = 1'b0; reqSub = 1'b0; reqA = '0; reqB = '0; rspReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    testCount++;
    if (reqReady !== 1'b1 || rspValid !== 1'b0) begin
      $display("[TB] FAIL reset_handshake: req_ready=%b rsp_valid=%b, required 1/0", reqReady, rspValid);
      failCount++;
    end
    testCount++;
    if ({rspResult, rspCarry, rspZero, rspOverflow} !== {W'(0), 3'b000}) begin
      $display("[TB] FAIL reset_rsp: result=%h c/z/o=%b%b%b, required 0000 000", rspResult, rspCarry, rspZero, rspOverflow);
      failCount++;
    end
    testCount++;
    if ({aluA, aluB, aluOp} !== 11'd0) begin
      $display("[TB] FAIL reset_alu: a=%h b=%h op=%b, required 0 0 000", aluA, aluB, aluOp);
      failCount++;
    end
  endtask

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         c;
    logic         z;
    logic         o;
  } vec_t;

  task automatic test_directed;
    vec_t vecs[$];
    logic [W-1:0] r;
    logic c, z, o;
    int lat, expLat;
    bit to;
    vecs.push_back('{1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 16'h5A5A, 16'h5A5A, 16'h0000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b0, 1'b0});
    foreach (vecs[k]) begin
      runOp(vecs[k].sub, vecs[k].a, vecs[k].b, r, c, z, o, lat, to);
      expLat = expLatency(vecs[k].sub, vecs[k].a, vecs[k].b);
      testCount++;
      if (to) begin
        $display("[TB] FAIL directed%0d timeout: no handshake within bound", k);
        failCount++;
      end
      testCount++;
      if (r !== vecs[k].r) begin
        $display("[TB] FAIL directed%0d result: got %h required %h", k, r, vecs[k].r);
        failCount++;
      end
      testCount++;
      if ({c, z, o} !== {vecs[k].c, vecs[k].z, vecs[k].o}) begin
        $display("[TB] FAIL directed%0d flags c/z/o: got %b%b%b required %b%b%b", k, c, z, o,
                 vecs[k].c, vecs[k].z, vecs[k].o);
        failCount++;
      end
      testCount++;
      if (lat !== expLat) begin
        $display("[TB] FAIL directed%0d latency: got %0d required %0d", k, lat, expLat);
        failCount++;
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, r, er;
    logic sub, c, z, o, ec, ez, eo;
    int lat;
    bit to;
    for (int k = 0; k < 30; k++) begin
      a   = W'($urandom);
      b   = (k % 5 == 0) ? a : W'($urandom);
      sub = 1'($urandom);
      refModel(sub, a, b, er, ec, ez, eo);
      runOp(sub, a, b, r, c, z, o, lat, to);
      testCount++;
      if (to || r !== er) begin
        $display("[TB] FAIL random%0d result (sub=%b a=%h b=%h): got %h required %h timeout=%b",
                 k, sub, a, b, r, er, to);
        failCount++;
      end
      testCount++;
      if ({c, z, o} !== {ec, ez, eo}) begin
        $display("[TB] FAIL random%0d flags c/z/o (sub=%b a=%h b=%h): got %b%b%b required %b%b%b",
                 k, sub, a, b, c, z, o, ec, ez, eo);
        failCount++;
      end
      testCount++;
      if (lat !== expLatency(sub, a, b)) begin
        $display("[TB] FAIL random%0d latency: got %0d required %0d", k, lat, expLatency(sub, a, b));
        failCount++;
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] snapR, r;
    logic snapC, snapZ, snapO, c, z, o;
    bit unstable, readyHigh, to;
    int lat;
    rspReady = 1'b0;
    reqSub = 1'b0; reqA = 16'h1234; reqB = 16'h0FFF; reqValid = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
    lat = 0;
    while (!rspValid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    testCount++;
    if (rspValid !== 1'b1 || rspResult !== 16'h2233) begin
      $display("[TB] FAIL backpressure_first: valid=%b result=%h, required 1 2233", rspValid, rspResult);
      failCount++;
    end
    snapR = rspResult; snapC = rspCarry; snapZ = rspZero; snapO = rspOverflow;
    unstable = 1'b0; readyHigh = 1'b0;
    reqValid = 1'b1; reqSub = 1'b1; reqA = 16'h5A5A; reqB = 16'h5A5A;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (rspValid !== 1'b1 || rspResult !== snapR || rspCarry !== snapC ||
          rspZero !== snapZ || rspOverflow !== snapO) unstable = 1'b1;
      if (reqReady !== 1'b0) readyHigh = 1'b1;
    end
    testCount++;
    if (unstable) begin
      $display("[TB] FAIL backpressure_stable: rsp changed while stalled, now %h, required %h", rspResult, snapR);
      failCount++;
    end
    testCount++;
    if (readyHigh) begin
      $display("[TB] FAIL backpressure_req_ready: req_ready seen 1, required 0 while stalled");
      failCount++;
    end
    rspReady = 1'b1;
    @(posedge clk); #1;
    testCount++;
    if (reqReady !== 1'b1 || rspValid !== 1'b0) begin
      $display("[TB] FAIL after_handshake: req_ready=%b rsp_valid=%b, required 1/0", reqReady, rspValid);
      failCount++;
    end
    runOp(1'b1, 16'h5A5A, 16'h5A5A, r, c, z, o, lat, to);
    testCount++;
    if (to || r !== 16'h0000 || {c, z, o} !== 3'b010 || lat !== expLatency(1'b1, 16'h5A5A, 16'h5A5A)) begin
      $display("[TB] FAIL back_to_back: result=%h c/z/o=%b%b%b lat=%0d, required 0000 010 lat %0d",
               r, c, z, o, lat, expLatency(1'b1, 16'h5A5A, 16'h5A5A));
      failCount++;
    end
  endtask

  task automatic test_reset_mid_op;
    logic [W-1:0] r;
    logic c, z, o;
    bit sawValid, to;
    int lat;
    rspReady = 1'b1;
    reqSub = 1'b0; reqA = 16'hFFFF; reqB = 16'hFFFF; reqValid = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    testCount++;
    if (reqReady !== 1'b1 || rspValid !== 1'b0) begin
      $display("[TB] FAIL reset_mid_op: req_ready=%b rsp_valid=%b, required 1/0", reqReady, rspValid);
      failCount++;
    end
    sawValid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (rspValid !== 1'b0) sawValid = 1'b1;
    end
    testCount++;
    if (sawValid) begin
      $display("[TB] FAIL reset_discard: rsp_valid seen 1 after reset, required 0");
      failCount++;
    end
    runOp(1'b0, 16'h0001, 16'h0001, r, c, z, o, lat, to);
    testCount++;
    if (to || r !== 16'h0002 || {c, z, o} !== 3'b000) begin
      $display("[TB] FAIL after_reset_add: result=%h c/z/o=%b%b%b, required 0002 000", r, c, z, o);
      failCount++;
    end
  endtask

  task automatic test_alu_op_monitor;
    testCount++;
    if (aluOpViolations !== 0) begin
      $display("[TB] FAIL alu_op_legal: %0d illegal opcodes seen, required 0", aluOpViolations);
      failCount++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    test_alu_op_monitor();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_nibble_sequencer.md
Name: alu_nibble_sequencer

Overview:
- Sequential initiator for the team's 4-bit combinational ALU (a/b/op in; result/carry/zero/overflow out).
- Performs NIBBLES*4-bit ADD/SUB by driving the ALU one nibble at a time.
- Consumes the ALU's carry and zero flags to chain nibbles. The ALU has no carry-in, so each nibble takes two ALU passes.
- Sits between a valid/ready request source and a valid/ready result sink; the ALU is instantiated outside and wired to the alu_* ports.

Parameters:
- NIBBLES, 4, number of 4-bit slices. Operand width W = 4*NIBBLES. Legal range 2..8.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request valid
- req_ready  output  1  request accepted when req_valid && req_ready
- req_sub  input  1  0 = ADD, 1 = SUB (a - b)
- req_a  input  W  operand a
- req_b  input  W  operand b
- rsp_valid  output  1  result valid
- rsp_ready  input  1  sink accepts result
- rsp_result  output  W  sum or difference, mod 2^W
- rsp_carry  output  1  ADD: carry out of MSB; SUB: borrow (1 iff a < b unsigned)
- rsp_zero  output  1  rsp_result == 0
- rsp_overflow  output  1  signed two's-complement overflow
- alu_a  output  4  ALU operand a
- alu_b  output  4  ALU operand b
- alu_op  output  3  ALU opcode; only 3'b000 ADD or 3'b001 SUB is ever driven
- alu_result  input  4  ALU result, combinational from alu_* in the same cycle
- alu_carry  input  1  ALU bit-4 carry/borrow
- alu_zero  input  1  ALU zero flag
- alu_overflow  input  1  unused; do not consume

Behaviour:
- Reset: every output register cleared. State IDLE, req_ready=1, rsp_valid=0, rsp_result=0, all rsp flags 0, alu_a=alu_b=0, alu_op=3'b000.
- States: IDLE, P1, P2, DONE. Nibble index i runs 0..NIBBLES-1.
- IDLE: req_ready=1. On accept, latch req_a, req_b and req_sub; set i=0, cin=0, zero_acc=1; go to P1.
  - req_ready is 0 in every other state.
- P1:
  - Drive alu_a=a[4i+3:4i], alu_b=b[4i+3:4i], alu_op=ADD or SUB.
  - Capture t=alu_result and c1=alu_carry; go to P2.
- P2:
  - Drive alu_a=t, alu_b={3'b000,cin}, same op.
  - Write result nibble i = alu_result; cin <= c1 | alu_carry; zero_acc <= zero_acc & alu_zero.
  - If i == NIBBLES-1, go to DONE. Otherwise i <= i+1 and go to P1.
- Outside P1/P2: alu_a=0, alu_b=0, alu_op=3'b000.
- DONE:
  - rsp_valid=1 and rsp_carry=final cin; rsp_zero=zero_acc.
  - rsp_overflow is computed from the latched sign bits and result MSB:
    - ADD: (~a[W-1] & ~b[W-1] & r[W-1]) | (a[W-1] & b[W-1] & ~r[W-1])
    - SUB: (~a[W-1] & b[W-1] & r[W-1]) | (a[W-1] & ~b[W-1] & ~r[W-1])
  - All rsp_* outputs hold stable while rsp_valid && !rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE; req_ready=1 from the next cycle. There is no same-cycle re-accept.
- Latency: rsp_valid rises exactly 2*NIBBLES edges after the accepting edge. Throughput is one op per 2*NIBBLES+2 cycles minimum.
- c1 and the P2 carry are never both 1. The OR is the architectural rule regardless.
- req_valid/req_a/req_b changes while busy are ignored. The latched operands are used.
- rst asserted in any state: IDLE on the next edge, rsp_valid=0, the in-flight op is discarded and no response is produced.

Optional Feature:
- Macro: ALU_NIBBLE_SEQUENCER_SKIP_EN.
- When defined: in P1, if cin == 0, write the nibble directly from the P1 ALU result and set cin <= alu_carry and zero_acc <= zero_acc & alu_zero. P2 is skipped and the block advances to the next P1 or to DONE.
  - Latency = NIBBLES + (number of nibbles i >= 1 entered with cin = 1).
- When undefined: fixed 2*NIBBLES latency as above. Results and flags are identical in both builds.

Test Plan:
- ADD 0x1234 + 0x0FFF -> rsp_result=0x2233, carry=0, zero=0, overflow=0; rsp_valid exactly 8 edges after accept. A monitor checks alu_op is only ever 000 or 001.
- ADD 0x7FFF + 0x0001 -> 0x8000, overflow=1, carry=0. ADD 0xFFFF + 0x0001 -> 0x0000, carry=1, zero=1, overflow=0.
- SUB 0x0000 - 0x0001 -> 0xFFFF, carry(borrow)=1, overflow=0. SUB 0x8000 - 0x0001 -> 0x7FFF, overflow=1, carry=0. SUB 0x5A5A - 0x5A5A -> 0x0000, zero=1, carry=0.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_* stable and req_ready=0 throughout. Then rsp_ready=1 -> handshake, req_ready=1 on the next cycle, and a back-to-back request is accepted there.
- Reset mid-op: assert rst for 1 cycle during P2 of nibble 1 -> next cycle req_ready=1, rsp_valid=0, no response emitted. A following ADD 0x0001 + 0x0001 -> 0x0002.
- With ALU_NIBBLE_SEQUENCER_SKIP_EN: ADD 0x0001 + 0x0001 -> latency 4. ADD 0x0FFF + 0x0001 -> latency 7 (3 carried nibbles), result 0x1000. Without the macro, both take latency 8.
